// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver. Oversamples the codec's SCLK/LRCLK/SDOUT with
// the system clock, deserializes MSB-first slots with the standard one-bit
// I2S delay, pairs left/right words once frame alignment is acquired and
// hands the pairs to fabric logic through a first-word-fallthrough FIFO.
`timescale 1ns/1ps

module i2s_rx #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          SCLK,
    input  logic                          LRCLK,
    input  logic                          SDOUT,
    input  logic                          Sample_Ready,
    output logic                          Sample_Valid,
    output logic [DATA_W-1:0]             Left_Out,
    output logic [DATA_W-1:0]             Right_Out,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level,
    output logic                          Overflow,
    output logic                          Synced
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int IDX_W  = $clog2(DATA_W);
    localparam int CNT_W  = 6;
    localparam int PAIR_W = 2 * DATA_W;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(32);
    localparam logic [CNT_W-1:0] CNT_KEEP = CNT_W'(DATA_W);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Input conditioning
    logic r_sclk_meta, r_sclk_sync, r_sclk_dly;
    logic r_lr_meta, r_lr_sync;
    logic r_sd_meta, r_sd_sync;

    // Deserializer state
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_lr_prev;
    logic              r_synced;
    logic [DATA_W-1:0] r_left_hold;
    logic              r_left_ok;
    logic              r_push;
    logic [PAIR_W-1:0] r_push_pair;

    // FIFO state
    logic [PAIR_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_overflow;

    logic              w_bit_evt;
    logic              w_lr_change;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_word;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;
    logic              w_drop;

    // Two-flop synchronizers on all three I2S inputs, plus a third SCLK stage for edge detection
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_dly  <= 1'b0;
            r_lr_meta   <= 1'b0;
            r_lr_sync   <= 1'b0;
            r_sd_meta   <= 1'b0;
            r_sd_sync   <= 1'b0;
        end else begin
            r_sclk_meta <= SCLK;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_dly  <= r_sclk_sync;
            r_lr_meta   <= LRCLK;
            r_lr_sync   <= r_lr_meta;
            r_sd_meta   <= SDOUT;
            r_sd_sync   <= r_sd_meta;
        end
    end

    // LRCLK and SDOUT share the SCLK synchronizer depth, so they are sampled on the rising-edge cycle
    assign w_bit_evt   = r_sclk_sync & ~r_sclk_dly;
    assign w_lr_change = r_lr_sync != r_lr_prev;

    // Current shift word with this event's bit inserted; bits past DATA_W are dropped
    always_comb begin
        // NOTE: defaults first so no path leaves w_word/w_idx unassigned and no latch is inferred.
        w_word = r_shift;
        w_idx  = IDX_W'(DATA_W - 1) - IDX_W'(r_bit_cnt);
        if (r_bit_cnt < CNT_KEEP) begin
            w_word[w_idx] = r_sd_sync;
        end
    end

    // Slot framing, frame alignment and left/right pairing; a finished pair becomes a one-cycle push request
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_lr_prev   <= 1'b0;
            r_synced    <= 1'b0;
            r_left_hold <= '0;
            r_left_ok   <= 1'b0;
            r_push      <= 1'b0;
            r_push_pair <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_bit_evt) begin
                if (!w_lr_change) begin
                    r_shift <= w_word;
                    if (r_bit_cnt != CNT_MAX) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end else begin
                    // LRCLK moved: this bit is the LSB slot of the slot named by r_lr_prev
                    r_shift   <= '0;
                    r_bit_cnt <= '0;
                    r_lr_prev <= r_lr_sync;
                    if (!r_synced) begin
                        // Only a right->left boundary marks a frame start
                        if (r_lr_prev) begin
                            r_synced <= 1'b1;
                        end
                    end else if (!r_lr_prev) begin
                        r_left_hold <= w_word;
                        r_left_ok   <= 1'b1;
                    end else if (r_left_ok) begin
                        r_push      <= 1'b1;
                        r_push_pair <= {r_left_hold, w_word};
                        r_left_ok   <= 1'b0;
                    end
                end
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign w_full = r_level == LVL_FULL;
    assign w_pop  = (r_level != '0) & Sample_Ready;
    assign w_wr   = r_push & (~w_full | w_pop);
    assign w_drop = r_push & w_full & ~w_pop;

    // FIFO storage; cleared on reset so the head reads zero before the first push
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: this memory is reset on purpose; Left_Out/Right_Out must read 0 until the first push.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_pair;
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign Sample_Valid = r_level != '0;
    assign Left_Out     = r_mem[r_rd_ptr][PAIR_W-1 -: DATA_W];
    assign Right_Out    = r_mem[r_rd_ptr][DATA_W-1:0];
    assign Fifo_Level   = r_level;
    assign Overflow     = r_overflow;
    assign Synced       = r_synced;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives an I2S codec stream into i2s_rx and compares popped pairs,
// level, overflow and sync status against a slot-level reference model.
`timescale 1ns/1ps

module tb_i2s_rx;

    localparam int DATA_W     = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int PAIR_W     = 2 * DATA_W;

    logic                        Clk = 1'b0;
    logic                        Reset = 1'b0;
    logic                        SCLK = 1'b0;
    logic                        LRCLK = 1'b0;
    logic                        SDOUT = 1'b0;
    logic                        Sample_Ready = 1'b0;
    logic                        Sample_Valid;
    logic [DATA_W-1:0]           Left_Out;
    logic [DATA_W-1:0]           Right_Out;
    logic [$clog2(FIFO_DEPTH):0] Fifo_Level;
    logic                        Overflow;
    logic                        Synced;

    i2s_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .SCLK         (SCLK),
        .LRCLK        (LRCLK),
        .SDOUT        (SDOUT),
        .Sample_Ready (Sample_Ready),
        .Sample_Valid (Sample_Valid),
        .Left_Out     (Left_Out),
        .Right_Out    (Right_Out),
        .Fifo_Level   (Fifo_Level),
        .Overflow     (Overflow),
        .Synced       (Synced)
    );

    always #10 Clk = ~Clk;   // 50 MHz

    int n_vec = 0;
    int n_err = 0;

    // Observed pops, captured mid-cycle when a handshake is about to complete
    logic [PAIR_W-1:0] obs_q[$];
    int                obs_cyc[$];
    int                cyc = 0;
    int                n_valid_cyc = 0;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (Sample_Valid) n_valid_cyc++;
        if (Sample_Valid && Sample_Ready) begin
            obs_q.push_back({Left_Out, Right_Out});
            obs_cyc.push_back(cyc);
        end
    end

    // Reference model: works on whole slots, not on individual bit events
    logic [PAIR_W-1:0] exp_q[$];
    bit                m_synced, m_left_ok, m_ready, m_ovf, m_pop_same;
    int                m_occ;
    logic [DATA_W-1:0] m_left;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // A len-bit slot keeps its top DATA_W bits, or is zero-padded on the right when shorter
    function automatic logic [DATA_W-1:0] exp_word(input logic [31:0] data, input int len);
        logic [63:0] v;
        v = {32'd0, data} & ((64'd1 << len) - 64'd1);
        if (len >= DATA_W) return DATA_W'(v >> (len - DATA_W));
        return DATA_W'(v << (DATA_W - len));
    endfunction

    function automatic void model_reset();
        m_synced  = 1'b0;
        m_left_ok = 1'b0;
        m_ovf     = 1'b0;
        m_occ     = 0;
    endfunction

    function automatic void model_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        if (!m_ready && m_occ == FIFO_DEPTH && !m_pop_same) begin
            m_ovf = 1'b1;
        end else begin
            exp_q.push_back({l, r});
            if (!m_ready && !m_pop_same) m_occ++;
        end
    endfunction

    function automatic void model_slot(input logic lr, input logic [31:0] data, input int len);
        logic [DATA_W-1:0] w;
        w = exp_word(data, len);
        if (!m_synced) begin
            if (lr) m_synced = 1'b1;
        end else if (!lr) begin
            m_left    = w;
            m_left_ok = 1'b1;
        end else if (m_left_ok) begin
            m_left_ok = 1'b0;
            model_pair(m_left, w);
        end
    endfunction

    // One SCLK period, 4 Clk cycles per phase; optional Ready pulse timed to the FIFO write cycle
    task automatic send_bit(input logic lr, input logic d, input bit pulse);
        LRCLK = lr;
        SDOUT = d;
        repeat (4) @(negedge Clk);
        SCLK = 1'b1;
        if (pulse) begin
            repeat (3) @(posedge Clk);
            #2 Sample_Ready = 1'b1;
            @(posedge Clk);
            #2 Sample_Ready = 1'b0;
            @(negedge Clk);
        end else begin
            repeat (4) @(negedge Clk);
        end
        SCLK = 1'b0;
    endtask

    // Slot of len bits MSB-first; when closed, the LSB carries the next slot's LRCLK
    task automatic send_slot(input logic lr, input logic [31:0] data, input int len,
                             input bit close, input bit pulse);
        for (int i = len - 1; i >= 0; i--) begin
            send_bit((i == 0 && close) ? ~lr : lr, data[i], (i == 0) && pulse);
        end
    endtask

    task automatic frame(input logic [31:0] l, input int ll, input logic [31:0] r, input int rl);
        send_slot(1'b0, l, ll, 1'b1, 1'b0);
        model_slot(1'b0, l, ll);
        send_slot(1'b1, r, rl, 1'b1, 1'b0);
        model_slot(1'b1, r, rl);
    endtask

    task automatic set_ready(input logic v);
        @(posedge Clk);
        #2 Sample_Ready = v;
        m_ready = v;
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #2 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #2 Reset = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " valid"},    64'(Sample_Valid), 64'd0);
        check({tag, " left"},     64'(Left_Out),     64'd0);
        check({tag, " right"},    64'(Right_Out),    64'd0);
        check({tag, " level"},    64'(Fifo_Level),   64'd0);
        check({tag, " overflow"}, 64'(Overflow),     64'd0);
        check({tag, " synced"},   64'(Synced),       64'd0);
    endtask

    task automatic check_pops(input string tag);
        check({tag, " pop count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s pair %0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int          v0;
        int          span;
        logic [31:0] a, b;
        int          la, lb;

        m_ready    = 1'b0;
        m_pop_same = 1'b0;
        model_reset();

        // Reset values with SCLK idle
        do_reset();
        check_reset_values("reset");

        // Alignment: start mid-right-slot, then one nominal 32-bit-slot frame
        set_ready(1'b1);
        v0 = n_valid_cyc;
        send_slot(1'b1, 32'h0000_03C5, 10, 1'b1, 1'b0);
        model_slot(1'b1, 32'h0000_03C5, 10);
        repeat (4) @(posedge Clk);
        check("synced after right->left", 64'(Synced), 64'(m_synced));
        frame(32'hA5A5_A5FF, 32, 32'h5A5A_5AFF, 32);
        repeat (16) @(posedge Clk);
        check("nominal left literal", 64'(exp_q.size() > 0 ? exp_q[0][PAIR_W-1 -: DATA_W] : '0), 64'h00A5_A5A5);
        check_pops("nominal");
        check("nominal valid cycles", 64'(n_valid_cyc - v0), 64'd1);

        // Short 16-bit slots are zero-padded in the LSBs
        frame(32'h0000_1234, 16, 32'h0000_BEEF, 16);
        repeat (16) @(posedge Clk);
        check_pops("short");

        // Random data and slot lengths with Ready held high
        for (int k = 0; k < 5; k++) begin
            a  = $urandom;
            b  = $urandom;
            la = $urandom_range(8, 32);
            lb = $urandom_range(8, 32);
            frame(a, la, b, lb);
        end
        repeat (16) @(posedge Clk);
        check_pops("random");

        // Backpressure: five frames into a four-deep FIFO
        set_ready(1'b0);
        for (int n = 1; n <= 5; n++) begin
            frame(32'(n), DATA_W, ~32'(n), DATA_W);
        end
        repeat (16) @(posedge Clk);
        check("bp level", 64'(Fifo_Level), 64'(m_occ));
        check("bp overflow", 64'(Overflow), 64'(m_ovf));
        set_ready(1'b1);
        m_occ = 0;
        repeat (12) @(posedge Clk);
        span = (obs_cyc.size() >= 4) ? obs_cyc[3] - obs_cyc[0] : -1;
        check("bp pops back-to-back", 64'(span), 64'd3);
        check("bp overflow sticky", 64'(Overflow), 64'(m_ovf));
        check("bp level drained", 64'(Fifo_Level), 64'd0);
        check_pops("bp");

        // Push and pop on the same cycle while full
        do_reset();
        set_ready(1'b0);
        send_slot(1'b1, $urandom, 20, 1'b1, 1'b0);
        model_slot(1'b1, 32'd0, 20);
        for (int n = 1; n <= 4; n++) begin
            frame($urandom, DATA_W, $urandom, DATA_W);
        end
        repeat (16) @(posedge Clk);
        check("full level", 64'(Fifo_Level), 64'(FIFO_DEPTH));
        a = $urandom;
        b = $urandom;
        send_slot(1'b0, a, 32, 1'b1, 1'b0);
        model_slot(1'b0, a, 32);
        send_slot(1'b1, b, 32, 1'b1, 1'b1);
        m_pop_same = 1'b1;
        model_slot(1'b1, b, 32);
        m_pop_same = 1'b0;
        repeat (16) @(posedge Clk);
        check("simul level", 64'(Fifo_Level), 64'(FIFO_DEPTH));
        check("simul overflow", 64'(Overflow), 64'(m_ovf));
        set_ready(1'b1);
        m_occ = 0;
        repeat (12) @(posedge Clk);
        check_pops("simul");

        // Reset halfway through a left slot, then realign
        send_slot(1'b0, $urandom, 16, 1'b0, 1'b0);
        do_reset();
        check_reset_values("midreset");
        a = $urandom;
        send_slot(1'b0, a, 16, 1'b1, 1'b0);
        model_slot(1'b0, a, 16);
        b = $urandom;
        send_slot(1'b1, b, 32, 1'b1, 1'b0);
        model_slot(1'b1, b, 32);
        frame($urandom, 32, $urandom, 32);
        repeat (16) @(posedge Clk);
        check("midreset synced", 64'(Synced), 64'(m_synced));
        check_pops("midreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Receives the codec's ADC data stream over I2S and delivers stereo sample pairs to fabric logic through a small first-word-fallthrough FIFO with a valid/ready handshake. It is the receive-side counterpart of the top-level I2S transmit path. The FPGA is the I2S slave: the codec drives SCLK and LRCLK on the Arduino header, and the codec's serial data-out pin enters here. All three I2S inputs are asynchronous to the system clock and are oversampled by the 50 MHz clock.

## Interface
Parameters:
- DATA_W, 24: bits kept per channel, MSB-first; legal range 8–32.
- FIFO_DEPTH, 4: stereo pairs buffered; must be a power of two, at least 2.

Ports:
- Clk  in  1  system clock, MAX10_CLK1_50 (50 MHz).
- Reset  in  1  synchronous, active-high; clears all state on the next Clk edge.
- SCLK  in  1  I2S bit clock from the codec; asynchronous to Clk.
- LRCLK  in  1  I2S word select from the codec; 0 = left, 1 = right; asynchronous.
- SDOUT  in  1  I2S serial data from the codec's ADC; asynchronous.
- Sample_Ready  in  1  consumer accepts the head pair.
- Sample_Valid  out  1  FIFO non-empty; head pair is on the outputs.
- Left_Out  out  DATA_W  head-pair left sample.
- Right_Out  out  DATA_W  head-pair right sample.
- Fifo_Level  out  $clog2(FIFO_DEPTH)+1  pairs currently stored.
- Overflow  out  1  sticky; set when a completed pair is dropped.
- Synced  out  1  frame alignment acquired.

## Operation
- Input conditioning: SCLK, LRCLK and SDOUT each pass through a 2-flop synchronizer. A third SCLK stage provides edge detection. A bit event fires on the cycle the synchronized SCLK is 1 and the delayed copy is 0. LRCLK and SDOUT are sampled on that same cycle.
- Bit event where sampled LRCLK equals lr_prev (LRCLK at the previous bit event): write the SDOUT bit into the shift word at index DATA_W-1-bit_cnt if bit_cnt < DATA_W. Increment bit_cnt, saturating at 32.
- Bit event where sampled LRCLK differs from lr_prev (one-bit I2S delay): this bit is the last bit of the closing slot. Write it by the same rule, then close the word as below. Clear the shift word and bit_cnt, and set lr_prev to the new LRCLK.
- Word storage is pre-cleared, so slots shorter than DATA_W are zero-padded in the LSBs. Bits beyond DATA_W are ignored.
- Word close with Synced=0: discard the word. If the closed slot was right (1→0 transition), set Synced.
- Word close with Synced=1, left slot: latch the word into left_hold and set left_ok.
- Word close with Synced=1, right slot: if left_ok is set, push {left_hold, word} and clear left_ok.
- Push rules:
  - FIFO not full: write the pair.
  - FIFO full with no pop in the same cycle: drop the pair and set Overflow.
  - FIFO full with a pop in the same cycle: write the pair; no overflow.
- Pop: occurs when Sample_Valid && Sample_Ready. The next entry appears on the outputs the following cycle.
- Fifo_Level arithmetic: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Reset behaviour: outputs read 0 until the first push. While Sample_Valid=0 after that, Left_Out and Right_Out are don't-care. Reset mid-frame discards the partial word and left_hold, and realignment is required.
- Reset values: Sample_Valid=0, Left_Out=0, Right_Out=0, Fifo_Level=0, Overflow=0, Synced=0. Internally lr_prev=0, bit_cnt=0, left_ok=0, FIFO pointers=0.

## Timing
- Input-to-detection latency: a codec SCLK rising edge produces a bit event 2–3 Clk cycles later.
- SCLK high and low phases must each last at least 3 Clk cycles (SCLK ≤ 8 MHz). A 64×Fs SCLK at 48 kHz (3.072 MHz) is the nominal case.
- The word close is processed in the bit-event cycle (cycle t). The FIFO write occurs at t+1.
- Sample_Valid rises at t+2 when the FIFO was empty.
- The Synced rise is visible at t+1 after the discarded right-slot close.
- Overflow is visible at t+2 after the dropped push and stays set until Reset.
- Throughput: one pair per LRCLK period. The consumer may hold Sample_Ready low for up to FIFO_DEPTH frames without loss.

## Test plan
- Reset values: assert Reset for 2 cycles with SCLK idle → Sample_Valid=0, Left_Out=0, Right_Out=0, Fifo_Level=0, Overflow=0, Synced=0.
- Alignment and nominal frame (DATA_W=24, 32-bit slots): start the stream mid-right-slot, then send left 0xA5A5A5 followed by 8 bits 0xFF, then right 0x5A5A5A followed by 0xFF, with Ready=1.
  - Synced rises after the first right→left transition.
  - The partial pre-sync frame never appears.
  - The first output is exactly L=0xA5A5A5, R=0x5A5A5A, with Sample_Valid high 1 cycle.
- Short slots: 16-bit slots, left 0x1234, right 0xBEEF → L=0x123400, R=0xBEEF00.
- Backpressure and overflow: hold Ready=0 and send 5 synced frames with L=n, R=~n.
  - Fifo_Level=4 and Overflow=1; the fifth frame is lost.
  - Raising Ready pops frames 1–4 in order, one per cycle; Overflow stays 1.
- Simultaneous push and pop when full: fill the FIFO, then pulse Ready on the exact write cycle of the next pair → Fifo_Level stays 4, Overflow=0, and the new pair is the last popped.
- Reset mid-frame: assert Reset halfway through a left slot.
  - All outputs return to their reset values.
  - The next output pair is the first complete frame after the following right→left realignment.
